cpe_instr_seq: RTL and testbench

Parametrised instruction sequencer. It feeds the instruction input of cpe_cpu from a loadable on-chip program buffer, replacing hard-coded stimulus. It supports single-pass and looped playback, stall/abort control and an issued-instruction counter. It sits between the load/debug path and the CPU instruction port, in both simulation harnesses and FPGA builds.

---
 rtl/cpe_instr_seq.sv | 160 ++++++++++++++++
 tb/tb_cpe_instr_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpe_instr_seq.sv
// Instruction sequencer for cpe_cpu: a loadable program buffer played back
// one entry per cycle, in single-pass or looped mode, with stall and abort
// controls and a saturating issued-instruction counter.
module cpe_instr_seq #(
    parameter int unsigned            DATA_W    = 32,
    parameter int unsigned            DEPTH     = 16,
    parameter int unsigned            ADDR_W    = 4,
    parameter logic [DATA_W-1:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk_w_i,
    input  logic                res_w_i_l,
    input  logic                load_w_i_h,
    input  logic [DATA_W-1:0]   load_data_w_i,
    input  logic                clear_w_i_h,
    input  logic                start_w_i_h,
    input  logic                loop_w_i_h,
    input  logic                stall_w_i_h,
    input  logic                stop_w_i_h,
    output logic [DATA_W-1:0]   instr_w_o,
    output logic                instr_vld_w_o_h,
    output logic                busy_w_o_h,
    output logic                done_w_o_h,
    output logic                full_w_o_h,
    output logic [ADDR_W:0]     count_w_o,
    output logic [15:0]         issued_w_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state, state_d;
    logic [ADDR_W-1:0]   wr_ptr, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr, rd_ptr_d;
    logic [ADDR_W:0]     count, count_d;
    logic [15:0]         issued, issued_d;
    logic                loop_q, loop_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                vld_q, vld_d;
    logic                mem_we;
    logic                full;
    logic                last;

    assign full = (count == DEPTH_C);
    assign last = ({1'b0, rd_ptr} == (count - ONE_C));

    // Program buffer write port; contents deliberately survive reset.
    always_ff @(posedge clk_w_i) begin
        if (mem_we) begin
            mem[wr_ptr] <= load_data_w_i;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            issued  <= '0;
            loop_q  <= 1'b0;
            instr_q <= NOP_INSTR;
            vld_q   <= 1'b0;
        end else begin
            state   <= state_d;
            wr_ptr  <= wr_ptr_d;
            rd_ptr  <= rd_ptr_d;
            count   <= count_d;
            issued  <= issued_d;
            loop_q  <= loop_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
        end
    end

    // Next-state logic: clear overrides everything, then per-state behaviour.
    always_comb begin
        state_d  = state;
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        count_d  = count;
        issued_d = issued;
        loop_d   = loop_q;
        instr_d  = NOP_INSTR;
        vld_d    = 1'b0;
        mem_we   = 1'b0;

        if (clear_w_i_h) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_w_i_h && !full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr + 1'b1;
                        count_d  = count + ONE_C;
                    end
                    // Start sees the count including a same-cycle load.
                    if (start_w_i_h && (count_d != '0)) begin
                        state_d  = RUN;
                        rd_ptr_d = '0;
                        issued_d = '0;
                        loop_d   = loop_w_i_h;
                    end
                end
                RUN: begin
                    if (stop_w_i_h) begin
                        state_d = IDLE;
                    end else if (!stall_w_i_h) begin
                        instr_d = mem[rd_ptr];
                        vld_d   = 1'b1;
                        if (issued != 16'hFFFF) begin
                            issued_d = issued + 16'd1;
                        end
                        if (last) begin
                            if (loop_q) begin
                                rd_ptr_d = '0;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            rd_ptr_d = rd_ptr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start_w_i_h) begin
                        state_d  = RUN;
                        rd_ptr_d = '0;
                        issued_d = '0;
                        loop_d   = loop_w_i_h;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign instr_w_o       = instr_q;
    assign instr_vld_w_o_h = vld_q;
    assign busy_w_o_h      = (state == RUN);
    assign done_w_o_h      = (state == DONE);
    assign full_w_o_h      = full;
    assign count_w_o       = count;
    assign issued_w_o      = issued;

endmodule

// File: tb/tb_cpe_instr_seq.sv
// Scoreboard bench for cpe_instr_seq: stimulus pushes the expected issued
// instructions; a negedge monitor pops one for every valid output cycle.
module tb_cpe_instr_seq;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_l = 1'b0;
    logic              load = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic              loop = 1'b0;
    logic              stall = 1'b0;
    logic              stop = 1'b0;
    logic [DATA_W-1:0] instr;
    logic              vld, busy, done, full;
    logic [ADDR_W:0]   count;
    logic [15:0]       issued;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_q[$];

    cpe_instr_seq #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .NOP_INSTR(NOP)
    ) dut (
        .clk_w_i(clk),
        .res_w_i_l(rst_l),
        .load_w_i_h(load),
        .load_data_w_i(load_data),
        .clear_w_i_h(clear),
        .start_w_i_h(start),
        .loop_w_i_h(loop),
        .stall_w_i_h(stall),
        .stop_w_i_h(stop),
        .instr_w_o(instr),
        .instr_vld_w_o_h(vld),
        .busy_w_o_h(busy),
        .done_w_o_h(done),
        .full_w_o_h(full),
        .count_w_o(count),
        .issued_w_o(issued)
    );

    always #5 clk = ~clk;

    // Monitor: every valid output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_vld: got instr=%h, required no valid output", instr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (instr !== e) begin
                    errors++;
                    $display("FAIL issue_seq: got instr=%h, required %h", instr, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] d);
        load = 1'b1;
        load_data = d;
        tick();
        load = 1'b0;
    endtask

    task automatic push3();
        exp_q.push_back(32'hA0);
        exp_q.push_back(32'hA1);
        exp_q.push_back(32'hA2);
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1: reset, load 3, single-pass run ----
        #12;
        rst_l = 1'b1;
        tick();
        chk("rst_instr", instr, NOP);
        chk("rst_vld", {31'b0, vld}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_count", {27'b0, count}, 0);
        chk("rst_issued", {16'b0, issued}, 0);
        load_word(32'hA0);
        load_word(32'hA1);
        load_word(32'hA2);
        chk("t1_count", {27'b0, count}, 3);
        push3();
        start = 1'b1; loop = 1'b0;
        tick();
        start = 1'b0;
        chk("t1_busy", {31'b0, busy}, 1);
        chk("t1_first_lat", {31'b0, vld}, 0);
        repeat (3) tick();
        chk("t1_done_vld", {31'b0, vld}, 1);
        chk("t1_done", {31'b0, done}, 1);
        tick();
        chk("t1_nop", instr, NOP);
        chk("t1_vld0", {31'b0, vld}, 0);
        chk("t1_issued", {16'b0, issued}, 3);
        tick();
        chk("t1_q_empty", exp_q.size(), 0);

        // ---- 2: looped run, 7 issues, stop ----
        push3(); push3();
        exp_q.push_back(32'hA0);
        start = 1'b1; loop = 1'b1;
        tick();
        start = 1'b0; loop = 1'b0;
        repeat (7) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t2_busy", {31'b0, busy}, 0);
        chk("t2_done", {31'b0, done}, 0);
        chk("t2_vld", {31'b0, vld}, 0);
        chk("t2_issued", {16'b0, issued}, 7);
        chk("t2_count", {27'b0, count}, 3);
        tick();
        chk("t2_q_empty", exp_q.size(), 0);

        // ---- 3: stall on the 2nd issue cycle ----
        push3();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        chk("t3_stall_vld", {31'b0, vld}, 0);
        chk("t3_stall_nop", instr, NOP);
        tick();
        tick();
        chk("t3_done", {31'b0, done}, 1);
        tick();
        chk("t3_issued", {16'b0, issued}, 3);
        chk("t3_q_empty", exp_q.size(), 0);

        // ---- 4: fill to DEPTH, 17th load dropped ----
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t4_clr_count", {27'b0, count}, 0);
        chk("t4_clr_done", {31'b0, done}, 0);
        for (int i = 0; i < 16; i++) load_word(32'hB00 + i);
        chk("t4_full", {31'b0, full}, 1);
        chk("t4_count16", {27'b0, count}, 16);
        load_word(32'hB10);
        chk("t4_full_hold", {31'b0, full}, 1);
        chk("t4_count_hold", {27'b0, count}, 16);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'hB00 + i);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        chk("t4_done", {31'b0, done}, 1);
        tick();
        chk("t4_issued", {16'b0, issued}, 16);
        chk("t4_q_empty", exp_q.size(), 0);

        // ---- 5: async reset mid-run, then start with empty buffer ----
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load_word(32'hA0);
        load_word(32'hA1);
        load_word(32'hA2);
        exp_q.push_back(32'hA0);
        exp_q.push_back(32'hA1);
        start = 1'b1; loop = 1'b1;
        tick();
        start = 1'b0; loop = 1'b0;
        tick();
        tick();
        #5;
        rst_l = 1'b0;
        #1;
        chk("t5_rst_instr", instr, NOP);
        chk("t5_rst_vld", {31'b0, vld}, 0);
        chk("t5_rst_busy", {31'b0, busy}, 0);
        chk("t5_rst_issued", {16'b0, issued}, 0);
        tick();
        rst_l = 1'b1;
        chk("t5_q_empty", exp_q.size(), 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_empty_busy", {31'b0, busy}, 0);
        tick();
        chk("t5_empty_vld", {31'b0, vld}, 0);
        chk("t5_empty_count", {27'b0, count}, 0);

        // ---- 6: rerun from DONE, then clear + start ----
        load_word(32'hA0);
        load_word(32'hA1);
        load_word(32'hA2);
        push3();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        tick();
        chk("t6_done1", {31'b0, done}, 1);
        chk("t6_issued1", {16'b0, issued}, 3);
        push3();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_rerun_busy", {31'b0, busy}, 1);
        chk("t6_rerun_issued0", {16'b0, issued}, 0);
        repeat (3) tick();
        chk("t6_done2", {31'b0, done}, 1);
        tick();
        chk("t6_issued2", {16'b0, issued}, 3);
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        chk("t6_clr_count", {27'b0, count}, 0);
        chk("t6_clr_busy", {31'b0, busy}, 0);
        chk("t6_clr_done", {31'b0, done}, 0);
        chk("t6_clr_vld", {31'b0, vld}, 0);
        repeat (2) tick();
        chk("t6_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
